// File: rtl/riscv_run_controller_if.sv
// Debug command port of the run controller: valid/ready handshake with opcode and data.
interface riscv_run_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/riscv_run_controller.sv
// Run/halt/step sequencer owning the core's reset and clock enable, with a PC breakpoint.
// Optional RUNCTL_STEPCOUNT_EN: STEP executes cmd_data[15:0] cycles (0 means 1) instead of one.
module riscv_run_controller #(
  parameter int RESET_CYCLES = 4,
  parameter int CYCLE_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  riscv_run_controller_if.slave  cmd,
  input  logic [31:0]            i_pc,
  output logic                   o_cpu_en,
  output logic                   o_cpu_reset,
  output logic                   o_halted,
  output logic                   o_bp_hit,
  output logic [CYCLE_W-1:0]     o_cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES);

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_RESTART = 3'd4;
  localparam logic [2:0] OP_SET_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_BP  = 3'd6;

  typedef enum logic [1:0] {S_RST_HOLD, S_HALTED, S_RUN, S_STEP} state_t;

  state_t              r_state, w_state_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_first, w_first_nxt;
  logic                r_bp_valid, w_bp_valid_nxt;
  logic [31:0]         r_bp_addr, w_bp_addr_nxt;
  logic                r_bp_hit, w_bp_hit_nxt;
  logic [CYCLE_W-1:0]  r_cycle_count;
  logic                w_clear_cc;
  logic                w_accept;
  logic                w_bp_match;
`ifdef RUNCTL_STEPCOUNT_EN
  logic [15:0]         r_remaining, w_remaining_nxt;
  logic [15:0]         w_step_count;
  assign w_step_count = (cmd.cmd_data[15:0] == 16'd0) ? 16'd1 : cmd.cmd_data[15:0];
`endif

  // first masks the breakpoint for one cycle so a resume executes the stopped instruction
  assign w_bp_match    = r_bp_valid & (i_pc == r_bp_addr) & ~r_first;
  assign cmd.cmd_ready = (r_state == S_HALTED) | (r_state == S_RUN);
  assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;
  assign o_cpu_en      = ((r_state == S_RUN) | (r_state == S_STEP)) & ~w_bp_match;
  assign o_cpu_reset   = (r_state == S_RST_HOLD);
  assign o_halted      = (r_state == S_HALTED);
  assign o_bp_hit      = r_bp_hit;
  assign o_cycle_count = r_cycle_count;

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_first_nxt    = r_first;
    w_bp_valid_nxt = r_bp_valid;
    w_bp_addr_nxt  = r_bp_addr;
    w_bp_hit_nxt   = 1'b0;
    w_clear_cc     = 1'b0;
`ifdef RUNCTL_STEPCOUNT_EN
    w_remaining_nxt = r_remaining;
`endif
    case (r_state)
      S_RST_HOLD: begin
        w_hold_nxt = r_hold - 1'b1;
        if (r_hold <= 1) w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              w_state_nxt = S_RUN;
              w_first_nxt = 1'b1;
            end
            OP_STEP: begin
              w_state_nxt = S_STEP;
              w_first_nxt = 1'b1;
`ifdef RUNCTL_STEPCOUNT_EN
              w_remaining_nxt = w_step_count;
`endif
            end
            OP_RESTART: begin
              w_state_nxt = S_RST_HOLD;
              w_hold_nxt  = HOLD_INIT;
              w_clear_cc  = 1'b1;
            end
            OP_SET_BP: begin
              w_bp_valid_nxt = 1'b1;
              w_bp_addr_nxt  = cmd.cmd_data;
            end
            OP_CLR_BP: w_bp_valid_nxt = 1'b0;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        w_first_nxt = 1'b0;
        if (w_bp_match) begin
          w_state_nxt  = S_HALTED;
          w_bp_hit_nxt = 1'b1;
        end
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_HALT: w_state_nxt = S_HALTED;
            OP_RESTART: begin
              w_state_nxt = S_RST_HOLD;
              w_hold_nxt  = HOLD_INIT;
              w_clear_cc  = 1'b1;
            end
            OP_SET_BP: begin
              w_bp_valid_nxt = 1'b1;
              w_bp_addr_nxt  = cmd.cmd_data;
            end
            OP_CLR_BP: w_bp_valid_nxt = 1'b0;
            default: ;
          endcase
        end
      end
      S_STEP: begin
        w_first_nxt = 1'b0;
        if (w_bp_match) begin
          w_state_nxt  = S_HALTED;
          w_bp_hit_nxt = 1'b1;
        end else begin
`ifdef RUNCTL_STEPCOUNT_EN
          w_remaining_nxt = r_remaining - 16'd1;
          if (r_remaining <= 16'd1) w_state_nxt = S_HALTED;
`else
          w_state_nxt = S_HALTED;
`endif
        end
      end
      default: w_state_nxt = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_RST_HOLD;
      r_hold        <= HOLD_INIT;
      r_first       <= 1'b0;
      r_bp_valid    <= 1'b0;
      r_bp_addr     <= 32'd0;
      r_bp_hit      <= 1'b0;
      r_cycle_count <= '0;
`ifdef RUNCTL_STEPCOUNT_EN
      r_remaining   <= 16'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_first    <= w_first_nxt;
      r_bp_valid <= w_bp_valid_nxt;
      r_bp_addr  <= w_bp_addr_nxt;
      r_bp_hit   <= w_bp_hit_nxt;
`ifdef RUNCTL_STEPCOUNT_EN
      r_remaining <= w_remaining_nxt;
`endif
      if (w_clear_cc)    r_cycle_count <= '0;
      else if (o_cpu_en) r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_run_controller.sv
// Scoreboard bench: each command that ends in HALTED pushes the expected halt summary;
// a monitor compares it whenever the controller re-enters HALTED.
module tb_riscv_run_controller;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_RESTART = 3'd4;
  localparam logic [2:0] OP_SET_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_BP  = 3'd6;

  typedef struct {
    string       name;
    int          rst;
    int          en;
    int          hits;
    logic [31:0] cc;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        cpu_en;
  logic        cpu_reset;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_count;

  int total = 0;
  int bad   = 0;
  exp_t sbQ[$];

  int rstCnt = 0;
  int enCnt  = 0;
  int hitCnt = 0;
  logic prevHalted = 1'b0;

  riscv_run_controller_if bus ();

  riscv_run_controller #(.RESET_CYCLES(4), .CYCLE_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (bus.slave),
    .i_pc          (pc),
    .o_cpu_en      (cpu_en),
    .o_cpu_reset   (cpu_reset),
    .o_halted      (halted),
    .o_bp_hit      (bp_hit),
    .o_cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal core model: PC advances by 4 on each enabled cycle
  always @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset)   pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rstCnt = 0;
      enCnt = 0;
      hitCnt = 0;
      prevHalted = 1'b0;
    end else begin
      if (cpu_reset) rstCnt++;
      if (cpu_en) enCnt++;
      if (bp_hit) hitCnt++;
      if (halted && !prevHalted) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_halt: got halt entry expected none");
        end else begin
          e = sbQ.pop_front();
          checkOutput({e.name, ".rstCycles"}, rstCnt, e.rst);
          checkOutput({e.name, ".enCycles"}, enCnt, e.en);
          checkOutput({e.name, ".bpHits"}, hitCnt, e.hits);
          checkOutput({e.name, ".cycleCount"}, cycle_count, e.cc);
          checkOutput({e.name, ".pc"}, pc, e.pc);
        end
        rstCnt = 0;
        enCnt = 0;
        hitCnt = 0;
      end
      prevHalted = halted;
    end
  end

  task automatic pushExp(input string name, input int rst, input int en, input int hits,
                         input logic [31:0] cc, input logic [31:0] epc);
    exp_t e;
    e.name = name;
    e.rst = rst;
    e.en = en;
    e.hits = hits;
    e.cc = cc;
    e.pc = epc;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] data);
    int waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = data;
    while (!bus.cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL cmd_accept_timeout: got ready=0 expected ready=1 (op %0d)", op);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int waited = 0;
    while (sbQ.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.timeout: got %0d pending expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  initial begin
    int stepEn;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_data = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.cpu_reset", cpu_reset, 1);
    checkOutput("reset.cpu_en", cpu_en, 0);
    checkOutput("reset.halted", halted, 0);
    checkOutput("reset.cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset.cycle_count", cycle_count, 0);
    checkOutput("reset.bp_hit", bp_hit, 0);

    pushExp("powerup", 4, 0, 0, 32'd0, 32'd0);
    reset = 1'b0;
    waitDrain("powerup");
    checkOutput("powerup.cmd_ready", bus.cmd_ready, 1);
    checkOutput("powerup.cpu_en", cpu_en, 0);

    // RUN 10 cycles then HALT: 11 enabled cycles including the accept cycle
    pushExp("runHalt", 0, 11, 0, 32'd11, 32'h2C);
    applyStimulus(OP_RUN, 32'd0);
    repeat (10) @(posedge clk);
    applyStimulus(OP_HALT, 32'd0);
    waitDrain("runHalt");

    pushExp("restart1", 4, 0, 0, 32'd0, 32'd0);
    applyStimulus(OP_RESTART, 32'd0);
    waitDrain("restart1");

    applyStimulus(OP_SET_BP, 32'h10);
    pushExp("bpStop", 0, 4, 1, 32'd4, 32'h10);
    applyStimulus(OP_RUN, 32'd0);
    waitDrain("bpStop");

    pushExp("bpResume", 0, 4, 0, 32'd8, 32'h20);
    applyStimulus(OP_RUN, 32'd0);
    repeat (3) @(posedge clk);
    applyStimulus(OP_HALT, 32'd0);
    waitDrain("bpResume");

    // HALT lands in the same cycle as the breakpoint at 0x28
    applyStimulus(OP_SET_BP, 32'h28);
    pushExp("haltVsBp", 0, 2, 1, 32'd10, 32'h28);
    applyStimulus(OP_RUN, 32'd0);
    repeat (2) @(posedge clk);
    applyStimulus(OP_HALT, 32'd0);
    waitDrain("haltVsBp");

`ifdef RUNCTL_STEPCOUNT_EN
    stepEn = 3;
`else
    stepEn = 1;
`endif
    pushExp("step3", 0, stepEn, 0, 32'(10 + stepEn), 32'(32'h28 + 4 * stepEn));
    applyStimulus(OP_STEP, 32'd3);
    checkOutput("step3.cmd_ready", bus.cmd_ready, 0);
    waitDrain("step3");

    applyStimulus(OP_CLR_BP, 32'd0);
    pushExp("step0", 0, 1, 0, 32'(11 + stepEn), 32'(32'h2C + 4 * stepEn));
    applyStimulus(OP_STEP, 32'd0);
    waitDrain("step0");

    // Async reset mid-RUN with a breakpoint armed at 0x8
    applyStimulus(OP_SET_BP, 32'h8);
    applyStimulus(OP_RUN, 32'd0);
    repeat (3) @(posedge clk);
    pushExp("midReset", 4, 0, 0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset.cpu_en", cpu_en, 0);
    checkOutput("midReset.cpu_reset", cpu_reset, 1);
    checkOutput("midReset.halted", halted, 0);
    checkOutput("midReset.cycle_count", cycle_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    waitDrain("midReset");

    pushExp("bpCleared", 0, 5, 0, 32'd5, 32'h14);
    applyStimulus(OP_RUN, 32'd0);
    repeat (4) @(posedge clk);
    applyStimulus(OP_HALT, 32'd0);
    waitDrain("bpCleared");

    applyStimulus(OP_SET_BP, 32'h30);
    pushExp("restartRun", 4, 2, 0, 32'd0, 32'd0);
    applyStimulus(OP_RUN, 32'd0);
    repeat (1) @(posedge clk);
    applyStimulus(OP_RESTART, 32'd0);
    waitDrain("restartRun");

    pushExp("bpKept", 0, 12, 1, 32'd12, 32'h30);
    applyStimulus(OP_RUN, 32'd0);
    waitDrain("bpKept");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
